fpr_writeback: RTL and testbench

Write-side sequencer for the floating-point register file. It accepts results from the multi-cycle FP ALU (buffered) and from the load return path (priority), and serialises them onto the file's single write port (regWr/Rw/busW). It keeps a 32-entry pending-write scoreboard that decode queries to stall on unresolved source registers.

---
 rtl/fpr_pkg.sv | 10 +
 rtl/fpr_wb_fifo.sv | 47 ++++
 rtl/fpr_writeback.sv | 92 +++++++++
 tb/tb_fpr_writeback.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/fpr_pkg.sv
// fpr_pkg: shared widths and the {rd, data} result record for FPR writeback.
package fpr_pkg;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;
  localparam int NUM_FPR = 32;
  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } fpr_result_t;
endpackage

// File: rtl/fpr_wb_fifo.sv
// fpr_wb_fifo: synchronous result FIFO with async active-high reset.
//   push_i/din_i  enqueue (ignored when full)
//   pop_i/dout_o  dequeue head (ignored when empty); dout_o shows the head
//   full_o/empty_o/count_o  occupancy status
module fpr_wb_fifo
  import fpr_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  fpr_result_t              din_i,
  output fpr_result_t              dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  fpr_result_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rd_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  // Pointers wrap for free because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + PW'(do_push);
      rd_q  <= rd_q + PW'(do_pop);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
endmodule

// File: rtl/fpr_writeback.sv
// fpr_writeback: serialises ALU (buffered) and load (priority) results onto the FPR write port.
//   issue_valid/issue_rd        mark a destination pending
//   alu_*                       ALU results into the FIFO
//   ld_*                        load results, granted ahead of the FIFO unless it is starving
//   query_rs/query_rt -> *_busy pending-write lookup for decode
//   regWr/Rw/busW               registered register-file write port
//   fifo_count                  FIFO occupancy
module fpr_writeback #(
  parameter int DEPTH      = 4,
  parameter int DATA_W     = fpr_pkg::DATA_W,
  parameter int ADDR_W     = fpr_pkg::ADDR_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_valid,
  input  logic [ADDR_W-1:0]      issue_rd,
  input  logic                   alu_valid,
  output logic                   alu_ready,
  input  logic [ADDR_W-1:0]      alu_rd,
  input  logic [DATA_W-1:0]      alu_data,
  input  logic                   ld_valid,
  output logic                   ld_ready,
  input  logic [ADDR_W-1:0]      ld_rd,
  input  logic [DATA_W-1:0]      ld_data,
  input  logic [ADDR_W-1:0]      query_rs,
  input  logic [ADDR_W-1:0]      query_rt,
  output logic                   rs_busy,
  output logic                   rt_busy,
  output logic                   regWr,
  output logic [ADDR_W-1:0]      Rw,
  output logic [DATA_W-1:0]      busW,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int NF = fpr_pkg::NUM_FPR;
  fpr_pkg::fpr_result_t alu_res, head;
  logic push, pop, ld_grant, fifo_full, fifo_empty;
  logic [SW-1:0] starve_q, starve_d;
  logic regwr_q, regwr_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] busw_q, busw_d;
  logic [NF-1:0] pending_q, pending_d;
  assign alu_res   = '{rd: alu_rd, data: alu_data};
  assign alu_ready = !fifo_full;
  assign push      = alu_valid && alu_ready;
  // Loads win unless they have already starved a non-empty FIFO for STARVE_MAX grants.
  assign ld_ready  = !(starve_q == SW'(STARVE_MAX) && !fifo_empty);
  assign ld_grant  = ld_valid && ld_ready;
  assign pop       = !ld_grant && !fifo_empty;
  assign rs_busy   = pending_q[query_rs];
  assign rt_busy   = pending_q[query_rt];
  assign regWr     = regwr_q;
  assign Rw        = rw_q;
  assign busW      = busw_q;
  fpr_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (alu_res),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );
  always_comb begin
    starve_d = (pop || fifo_empty) ? '0
             : (ld_grant && starve_q != SW'(STARVE_MAX)) ? starve_q + 1'b1 : starve_q;
    regwr_d  = ld_grant || pop;
    rw_d     = ld_grant ? ld_rd : pop ? head.rd : rw_q;
    busw_d   = ld_grant ? ld_data : pop ? head.data : busw_q;
    // Clear the register being written this cycle, then OR in a new issue so set wins.
    pending_d = (pending_q & ~(regwr_q ? NF'(1) << rw_q : NF'(0)))
              | (issue_valid ? NF'(1) << issue_rd : NF'(0));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_q  <= '0;
      regwr_q   <= 1'b0;
      rw_q      <= '0;
      busw_q    <= '0;
      pending_q <= '0;
    end else begin
      starve_q  <= starve_d;
      regwr_q   <= regwr_d;
      rw_q      <= rw_d;
      busw_q    <= busw_d;
      pending_q <= pending_d;
    end
  end
endmodule

// File: tb/tb_fpr_writeback.sv
// tb_fpr_writeback: directed self-checking bench for fpr_writeback.
module tb_fpr_writeback;
  logic        clk, reset;
  logic        issue_valid, alu_valid, alu_ready, ld_valid, ld_ready;
  logic [4:0]  issue_rd, alu_rd, ld_rd, query_rs, query_rt, Rw;
  logic [31:0] alu_data, ld_data, busW;
  logic        rs_busy, rt_busy, regWr;
  logic [2:0]  fifo_count;
  int n_cmp = 0;
  int n_err = 0;
  fpr_writeback dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .query_rs(query_rs), .query_rt(query_rt), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .regWr(regWr), .Rw(Rw), .busW(busW), .fifo_count(fifo_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    reset = 1'b1;
    {issue_valid, alu_valid, ld_valid} = '0;
    {issue_rd, alu_rd, ld_rd, query_rs, query_rt} = '0;
    alu_data = '0;
    ld_data  = '0;
    #3;
    chk("rst_regwr", regWr, 0);
    chk("rst_rw", Rw, 0);
    chk("rst_busw", busW, 0);
    chk("rst_count", fifo_count, 0);
    tick; tick;
    reset = 1'b0;
    #1;
    chk("rel_alu_ready", alu_ready, 1);
    chk("rel_ld_ready", ld_ready, 1);
    // single load
    issue_valid = 1; issue_rd = 3; query_rs = 3;
    tick;
    issue_valid = 0;
    chk("ld_busy_set", rs_busy, 1);
    ld_valid = 1; ld_rd = 3; ld_data = 32'h3F800000;
    tick;
    ld_valid = 0;
    chk("ld_regwr", regWr, 1);
    chk("ld_rw", Rw, 3);
    chk("ld_busw", busW, 32'h3F800000);
    chk("ld_busy_hold", rs_busy, 1);
    tick;
    chk("ld_regwr_off", regWr, 0);
    chk("ld_rw_hold", Rw, 3);
    chk("ld_busy_clr", rs_busy, 0);
    // ALU fill while loads keep the FIFO from draining
    for (int i = 1; i <= 5; i++) begin
      alu_valid = 1; alu_rd = 5'(i); alu_data = 32'hA0 + i;
      ld_valid = 1; ld_rd = 20; ld_data = 32'hD0 + i;
      tick;
      chk("fill_rw", Rw, 20);
      chk("fill_busw", busW, 32'hD0 + i);
      chk("fill_count", fifo_count, (i < 4) ? i : 4);
      chk("fill_alu_ready", alu_ready, (i < 4) ? 1 : 0);
    end
    chk("fill_ld_ready", ld_ready, 0);
    alu_valid = 0; ld_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("drain_regwr", regWr, 1);
      chk("drain_rw", Rw, i);
      chk("drain_busw", busW, 32'hA0 + i);
    end
    tick;
    chk("drain_done", regWr, 0);
    chk("drain_count", fifo_count, 0);
    // starvation
    alu_valid = 1; alu_rd = 7; alu_data = 32'h77;
    tick;
    alu_valid = 0;
    chk("st_nogrant", regWr, 0);
    chk("st_count", fifo_count, 1);
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_rd = 5'(10 + i); ld_data = 32'h100 + i;
      tick;
      chk("st_ld_rw", Rw, 10 + i);
    end
    chk("st_ld_ready_low", ld_ready, 0);
    ld_rd = 14; ld_data = 32'h104;
    tick;
    chk("st_alu_rw", Rw, 7);
    chk("st_alu_busw", busW, 32'h77);
    chk("st_ld_ready_back", ld_ready, 1);
    tick;
    chk("st_resume_rw", Rw, 14);
    chk("st_resume_busw", busW, 32'h104);
    ld_valid = 0;
    tick;
    // scoreboard set wins over clear
    ld_valid = 1; ld_rd = 9; ld_data = 32'h9;
    tick;
    ld_valid = 0; issue_valid = 1; issue_rd = 9;
    tick;
    issue_valid = 0; query_rt = 9;
    #1;
    chk("sb_set_wins", rt_busy, 1);
    ld_valid = 1;
    tick;
    ld_valid = 0;
    chk("sb_still_busy", rt_busy, 1);
    tick;
    chk("sb_cleared", rt_busy, 0);
    // query
    issue_valid = 1; issue_rd = 2;
    tick;
    issue_valid = 0; query_rs = 2; query_rt = 5;
    #1;
    chk("q_rs", rs_busy, 1);
    chk("q_rt", rt_busy, 0);
    issue_valid = 1; issue_rd = 5;
    #1;
    chk("q_same_cycle", rt_busy, 0);
    tick;
    issue_valid = 0;
    chk("q_next_cycle", rt_busy, 1);
    // reset mid-operation
    for (int i = 0; i < 3; i++) begin
      issue_valid = (i == 0); issue_rd = 4;
      alu_valid = 1; alu_rd = 5'(20 + i); alu_data = 32'hC0 + i;
      ld_valid = 1; ld_rd = 30; ld_data = 32'hE0;
      tick;
    end
    issue_valid = 0; alu_valid = 0; ld_valid = 0;
    chk("mr_count", fifo_count, 3);
    chk("mr_regwr", regWr, 1);
    #2;
    reset = 1;
    query_rs = 4; query_rt = 2;
    #1;
    chk("mr_regwr_rst", regWr, 0);
    chk("mr_count_rst", fifo_count, 0);
    chk("mr_rw_rst", Rw, 0);
    chk("mr_busw_rst", busW, 0);
    chk("mr_rs_busy", rs_busy, 0);
    chk("mr_rt_busy", rt_busy, 0);
    tick; tick;
    reset = 0;
    #1;
    chk("mr_alu_ready", alu_ready, 1);
    chk("mr_ld_ready", ld_ready, 1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("mr_no_write", regWr, 0);
      chk("mr_empty", fifo_count, 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
